// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg
// Shared definitions for the display arbiter and its tick generator:
// display data width, default hold-tick divider and the arbiter state
// encoding.
package disp_arbiter_pkg;

    localparam int DISP_W       = 16;
    localparam int DEF_TICK_DIV = 5000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_MIN = 2'd1,
        ST_OWN     = 2'd2,
        ST_SWITCH  = 2'd3
    } arb_state_e;

endpackage : disp_arbiter_pkg

// File: rtl/disp_arbiter_tick_gen.sv
// tick_gen
// Free-running prescaler counting 0..TICK_DIV-1. The tick output is high
// during the cycle in which the count sits at TICK_DIV-1, after which the
// count wraps to 0.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   tick - one-cycle pulse every TICK_DIV cycles
module tick_gen
    import disp_arbiter_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          tick_q;

    // Next prescaler count with wrap at TICK_DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST) begin
            cnt_d = {PW{1'b0}};
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Prescaler and registered tick; tick_q mirrors (cnt_q == LAST).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {PW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule : tick_gen

// File: rtl/disp_arbiter.sv
// disp_arbiter
// Time-shares one four-digit display between N requesters using a
// request/grant handshake with round-robin fairness. A grant is held for at
// least MIN_HOLD ticks regardless of the owner's request; after MAX_HOLD
// ticks a pending competitor preempts the owner. Every hand-over inserts one
// blank cycle.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous, active-high reset
//   req        - level request per requester (bit i = requester i)
//   value_in   - 16-bit display value per requester, packed by index
//   grant      - one-hot owner indication, zero when no owner
//   disp_value - value forwarded to the display (registered)
//   disp_blank - 1 when the display must be blanked
//   tick       - hold-tick pulse, exported for reuse
module disp_arbiter
    import disp_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MIN_HOLD = 10,
    parameter int MAX_HOLD = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [DISP_W*N-1:0]   value_in,
    output logic [N-1:0]          grant,
    output logic [DISP_W-1:0]     disp_value,
    output logic                  disp_blank,
    output logic                  tick
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [DISP_W-1:0]  disp_value_q, disp_value_d;
    logic               disp_blank_q, disp_blank_d;

    logic               tick_s;
    logic               pick_valid_s;
    logic [IW-1:0]      pick_idx_s;
    int                 best_dist_s;
    int                 dist_s;
    logic [HW-1:0]      hold_inc_s;
    logic               others_req_s;
    logic [IW-1:0]      owner_next_s;
    logic               owning_d_s;
    logic [DISP_W-1:0]  sel_value_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Round-robin pick: the set request closest at or after rr_ptr (modulo N).
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = {IW{1'b0}};
        best_dist_s  = N;
        dist_s       = 0;
        for (int i = 0; i < N; i++) begin
            dist_s = (i + N - int'(rr_ptr_q)) % N;
            if (req[i] && (dist_s < best_dist_s)) begin
                best_dist_s  = dist_s;
                pick_idx_s   = IW'(i);
                pick_valid_s = 1'b1;
            end else begin
                best_dist_s  = best_dist_s;
            end
        end
    end

    // Helper terms: saturating hold increment, competitor presence, next pointer.
    always_comb begin
        if (tick_s && (hold_cnt_q != HW'(MAX_HOLD))) begin
            hold_inc_s = hold_cnt_q + HW'(1);
        end else begin
            hold_inc_s = hold_cnt_q;
        end
        others_req_s = |(req & ~(N'(1) << owner_q));
        if (owner_q == IW'(N - 1)) begin
            owner_next_s = {IW{1'b0}};
        end else begin
            owner_next_s = owner_q + IW'(1);
        end
    end

    // Arbiter next-state logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d    = ST_OWN_MIN;
                    owner_d    = pick_idx_s;
                    hold_cnt_d = {HW{1'b0}};
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_OWN_MIN: begin
                // The owner's req is deliberately ignored until MIN_HOLD.
                hold_cnt_d = hold_inc_s;
                if (hold_inc_s >= HW'(MIN_HOLD)) begin
                    state_d = ST_OWN;
                end else begin
                    state_d = ST_OWN_MIN;
                end
            end
            ST_OWN: begin
                if (!req[owner_q] ||
                    ((hold_cnt_q >= HW'(MAX_HOLD)) && others_req_s)) begin
                    state_d  = ST_SWITCH;
                    rr_ptr_d = owner_next_s;
                end else begin
                    hold_cnt_d = hold_inc_s;
                end
            end
            ST_SWITCH: begin
                // rr_ptr_q already points past the previous owner here.
                if (pick_valid_s) begin
                    state_d    = ST_OWN_MIN;
                    owner_d    = pick_idx_s;
                    hold_cnt_d = {HW{1'b0}};
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values follow the next-cycle owner so value and grant align.
    always_comb begin
        owning_d_s  = (state_d == ST_OWN_MIN) || (state_d == ST_OWN);
        sel_value_s = {DISP_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (owner_d == IW'(i)) begin
                sel_value_s = value_in[i*DISP_W +: DISP_W];
            end else begin
                sel_value_s = sel_value_s;
            end
        end
        if (owning_d_s) begin
            grant_d      = N'(1) << owner_d;
            disp_value_d = sel_value_s;
            disp_blank_d = 1'b0;
        end else begin
            grant_d      = {N{1'b0}};
            disp_value_d = disp_value_q;
            disp_blank_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= {IW{1'b0}};
            rr_ptr_q     <= {IW{1'b0}};
            hold_cnt_q   <= {HW{1'b0}};
            grant_q      <= {N{1'b0}};
            disp_value_q <= {DISP_W{1'b0}};
            disp_blank_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            grant_q      <= grant_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    assign grant      = grant_q;
    assign disp_value = disp_value_q;
    assign disp_blank = disp_blank_q;
    assign tick       = tick_s;

endmodule : disp_arbiter
